// File: rtl/mlp_pkg.sv
// Shared types, constants and arithmetic helpers for the mlp perceptron.
//   sfp       : signed Q32.32 fixed-point word
//   act_func  : activation selector (ReLU, Sigmoid, Linear)
//   sfp_mul   : Q32.32 multiply (full product, >>> 32, low 64 bits kept)
//   int_to_sfp: integer to Q32.32
package mlp_pkg;

    typedef logic signed [63:0] sfp;

    typedef enum logic [1:0] {ReLU, Sigmoid, Linear} act_func;

    localparam sfp ZERO    = 64'sh0000_0000_0000_0000;
    localparam sfp ONE     = 64'sh0000_0001_0000_0000;
    localparam sfp HALF    = 64'sh0000_0000_8000_0000;
    localparam sfp QUARTER = 64'sh0000_0000_4000_0000;
    localparam sfp TWO     = 64'sh0000_0002_0000_0000;

    function automatic sfp sfp_mul(sfp a, sfp b);
        logic signed [127:0] ae;
        logic signed [127:0] be;
        logic signed [127:0] p;
        ae = {{64{a[63]}}, a};
        be = {{64{b[63]}}, b};
        p  = ae * be;
        // Taking bits [95:32] is the arithmetic shift by 32 truncated to 64 bits.
        return p[95:32];
    endfunction

    function automatic sfp int_to_sfp(int v);
        return {v, 32'h0000_0000};
    endfunction

endpackage

// File: rtl/mlp_if.sv
// Stimulus/prediction bundle of the mlp perceptron.
//   values, expected, hidden/output activation selects, training, learning_rate: to the core
//   prediction: registered output-layer activations from the core
interface mlp_if #(
    parameter int unsigned inputs  = 2,
    parameter int unsigned outputs = 1
) ();
    import mlp_pkg::*;

    sfp      values [inputs];
    sfp      expected [outputs];
    act_func hidden_activation;
    act_func output_activation;
    logic    training;
    sfp      learning_rate;
    sfp      prediction [outputs];

    modport master (
        output values, expected, hidden_activation, output_activation, training, learning_rate,
        input  prediction
    );

    modport slave (
        input  values, expected, hidden_activation, output_activation, training, learning_rate,
        output prediction
    );
endinterface

// File: rtl/mlp_activation.sv
// Combinational activation function and its derivative for one neuron.
//   z_i   : pre-activation
//   sel_i : activation select
//   y_o   : f(z)
//   dy_o  : f'(z)
module mlp_activation
    import mlp_pkg::*;
(
    input  sfp      z_i,
    input  act_func sel_i,
    output sfp      y_o,
    output sfp      dy_o
);
    sfp sig;

    always_comb begin
        y_o  = ZERO;
        dy_o = ZERO;
        sig  = (z_i >>> 2) + HALF;
        case (sel_i)
            ReLU: begin
                if (z_i > ZERO) begin
                    y_o  = z_i;
                    dy_o = ONE;
                end
            end
            Sigmoid: begin
                if (sig < ZERO) begin
                    y_o = ZERO;
                end else if (sig > ONE) begin
                    y_o = ONE;
                end else begin
                    y_o = sig;
                end
                // Slope is only non-zero strictly inside the linear segment.
                if ((z_i > -TWO) && (z_i < TWO)) begin
                    dy_o = QUARTER;
                end
            end
            Linear: begin
                y_o  = z_i;
                dy_o = ONE;
            end
            default: begin
                y_o  = ZERO;
                dy_o = ZERO;
            end
        endcase
    end
endmodule

// File: rtl/mlp.sv
// Two-layer perceptron with single-cycle SGD training.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : stimulus in, registered prediction out (see mlp_if)
// Forward pass is combinational from the weight registers; each edge registers
// the prediction and, when training, applies the backprop update computed from
// the pre-update weights.
module mlp
    import mlp_pkg::*;
#(
    parameter int unsigned inputs            = 2,
    parameter int unsigned hidden_layer_size = 2,
    parameter int unsigned outputs           = 1
) (
    input logic  clk,
    input logic  rst,
    mlp_if.slave bus_io
);
    sfp w1_q [hidden_layer_size][inputs];
    sfp w1_d [hidden_layer_size][inputs];
    sfp b1_q [hidden_layer_size];
    sfp b1_d [hidden_layer_size];
    sfp w2_q [outputs][hidden_layer_size];
    sfp w2_d [outputs][hidden_layer_size];
    sfp b2_q [outputs];
    sfp b2_d [outputs];
    sfp pred_q [outputs];

    sfp h  [hidden_layer_size];
    sfp dh [hidden_layer_size];
    sfp y  [outputs];
    sfp dy [outputs];
    sfp d2 [outputs];

    for (genvar j = 0; j < hidden_layer_size; j++) begin : g_hidden
        sfp z1;
        sfp bp;
        sfp d1;
        sfp lr_d1;

        always_comb begin
            z1 = b1_q[j];
            for (int i = 0; i < inputs; i++) begin
                z1 = z1 + sfp_mul(w1_q[j][i], bus_io.values[i]);
            end
        end

        mlp_activation u_act (
            .z_i  (z1),
            .sel_i(bus_io.hidden_activation),
            .y_o  (h[j]),
            .dy_o (dh[j])
        );

        // Error back-propagated through the pre-update output weights.
        always_comb begin
            bp = ZERO;
            for (int k = 0; k < outputs; k++) begin
                bp = bp + sfp_mul(w2_q[k][j], d2[k]);
            end
        end

        assign d1    = sfp_mul(bp, dh[j]);
        assign lr_d1 = sfp_mul(bus_io.learning_rate, d1);
        assign b1_d[j] = b1_q[j] - lr_d1;

        for (genvar i = 0; i < inputs; i++) begin : g_w1
            assign w1_d[j][i] = w1_q[j][i] - sfp_mul(lr_d1, bus_io.values[i]);
        end
    end

    for (genvar k = 0; k < outputs; k++) begin : g_output
        sfp z2;
        sfp lr_d2;

        always_comb begin
            z2 = b2_q[k];
            for (int j = 0; j < hidden_layer_size; j++) begin
                z2 = z2 + sfp_mul(w2_q[k][j], h[j]);
            end
        end

        mlp_activation u_act (
            .z_i  (z2),
            .sel_i(bus_io.output_activation),
            .y_o  (y[k]),
            .dy_o (dy[k])
        );

        assign d2[k]   = sfp_mul(y[k] - bus_io.expected[k], dy[k]);
        assign lr_d2   = sfp_mul(bus_io.learning_rate, d2[k]);
        assign b2_d[k] = b2_q[k] - lr_d2;

        for (genvar j = 0; j < hidden_layer_size; j++) begin : g_w2
            assign w2_d[k][j] = w2_q[k][j] - sfp_mul(lr_d2, h[j]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < hidden_layer_size; j++) begin
                b1_q[j] <= ZERO;
                for (int i = 0; i < inputs; i++) begin
                    // Checkerboard start breaks the symmetry between hidden neurons.
                    w1_q[j][i] <= (((i + j) % 2) == 0) ? HALF : -QUARTER;
                end
            end
            for (int k = 0; k < outputs; k++) begin
                b2_q[k]   <= ZERO;
                pred_q[k] <= ZERO;
                for (int j = 0; j < hidden_layer_size; j++) begin
                    w2_q[k][j] <= HALF;
                end
            end
        end else begin
            pred_q <= y;
            if (bus_io.training) begin
                w1_q <= w1_d;
                b1_q <= b1_d;
                w2_q <= w2_d;
                b2_q <= b2_d;
            end
        end
    end

    assign bus_io.prediction = pred_q;
endmodule

// File: tb/tb_mlp.sv
// Self-checking bench for mlp: table of inference vectors from the reset
// weights, then hand-written reset, training and convergence sequences.
module tb_mlp;
    import mlp_pkg::*;

    localparam sfp LR = 64'sh0000_0000_1999_999A;

    typedef struct {
        int      x0;
        int      x1;
        act_func hid;
        act_func out;
        sfp      want;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [13];

    always #5 clk = ~clk;

    mlp_if #(.inputs(2), .outputs(1)) bus ();

    mlp #(
        .inputs           (2),
        .hidden_layer_size(2),
        .outputs          (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    task automatic check(input string name, input sfp act, input sfp want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic check_cond(input string name, input bit ok, input sfp act, input string want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h, want %s", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int x0, input int x1, input act_func hid, input act_func out);
        bus.values[0]          = int_to_sfp(x0);
        bus.values[1]          = int_to_sfp(x1);
        bus.hidden_activation  = hid;
        bus.output_activation  = out;
    endtask

    // Asynchronous reset pulse placed between edges; prediction must clear at once.
    task automatic do_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        check(name, bus.prediction[0], ZERO);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        sfp diff;

        vecs[0]  = '{0,   0,   ReLU,    Sigmoid, 64'sh0000_0000_8000_0000};
        vecs[1]  = '{1,   1,   ReLU,    Sigmoid, 64'sh0000_0000_9000_0000};
        vecs[2]  = '{1,   0,   ReLU,    Sigmoid, 64'sh0000_0000_9000_0000};
        vecs[3]  = '{1,   0,   Linear,  Linear,  64'sh0000_0000_2000_0000};
        vecs[4]  = '{1,   1,   Linear,  Linear,  64'sh0000_0000_4000_0000};
        vecs[5]  = '{0,   1,   Linear,  Linear,  64'sh0000_0000_2000_0000};
        vecs[6]  = '{0,   1,   ReLU,    Linear,  64'sh0000_0000_4000_0000};
        vecs[7]  = '{-1,  0,   Linear,  Sigmoid, 64'sh0000_0000_7800_0000};
        vecs[8]  = '{-1,  -1,  ReLU,    ReLU,    64'sh0000_0000_0000_0000};
        vecs[9]  = '{1,   1,   Sigmoid, Sigmoid, 64'sh0000_0000_A400_0000};
        vecs[10] = '{8,   0,   Linear,  Sigmoid, 64'sh0000_0000_C000_0000};
        vecs[11] = '{32,  0,   Linear,  Sigmoid, 64'sh0000_0001_0000_0000};
        vecs[12] = '{-32, 0,   Linear,  Sigmoid, 64'sh0000_0000_0000_0000};

        rst                = 1'b1;
        bus.training       = 1'b0;
        bus.learning_rate  = LR;
        bus.expected[0]    = ZERO;
        set_in(0, 0, ReLU, Sigmoid);
        #12;
        check("reset_pred", bus.prediction[0], ZERO);
        rst = 1'b0;

        // Inference table; expected is junk to show it is ignored without training.
        for (int v = 0; v < 13; v++) begin
            set_in(vecs[v].x0, vecs[v].x1, vecs[v].hid, vecs[v].out);
            bus.expected[0] = {$urandom, $urandom};
            step();
            check($sformatf("vec%0d", v), bus.prediction[0], vecs[v].want);
        end

        set_in(1, 1, ReLU, Sigmoid);
        for (int n = 0; n < 10; n++) begin
            step();
            check($sformatf("hold%0d", n), bus.prediction[0], 64'sh0000_0000_9000_0000);
        end

        // Reset in the middle of a training run.
        bus.expected[0] = ZERO;
        bus.training    = 1'b1;
        step();
        step();
        do_reset("midrun_reset");

        // Single SGD step from reset on (1,1) -> 0.
        bus.training = 1'b1;
        set_in(1, 1, ReLU, Sigmoid);
        bus.expected[0] = ZERO;
        step();
        check("train_pre_pred", bus.prediction[0], 64'sh0000_0000_9000_0000);
        diff = dut.b2_q[0] + 64'sh0000_0000_0399_9999;
        check_cond("train_b2", (diff >= -1) && (diff <= 1), dut.b2_q[0], "-0x03999999 +-1");
        bus.training = 1'b0;
        step();
        check_cond("train_pred_drop", bus.prediction[0] < 64'sh0000_0000_9000_0000,
                   bus.prediction[0], "< 0x90000000");

        // Zero-input step toward ONE: only the output bias can move.
        do_reset("reset_zero_step");
        set_in(0, 0, ReLU, Sigmoid);
        bus.expected[0] = ONE;
        bus.training    = 1'b1;
        step();
        bus.training = 1'b0;
        step();
        check("zero_w1_00", dut.w1_q[0][0], HALF);
        check("zero_w1_01", dut.w1_q[0][1], -QUARTER);
        check("zero_b1_0", dut.b1_q[0], ZERO);
        check("zero_b2", dut.b2_q[0], 64'sh0000_0000_0333_3334);
        check("zero_pred", bus.prediction[0], 64'sh0000_0000_80CC_CCCD);

        // AND function, 200 epochs.
        do_reset("reset_and");
        bus.training = 1'b1;
        for (int ep = 0; ep < 200; ep++) begin
            for (int s = 0; s < 4; s++) begin
                set_in(s >> 1, s & 1, ReLU, Sigmoid);
                bus.expected[0] = (s == 3) ? ONE : ZERO;
                step();
            end
        end
        bus.training = 1'b0;
        for (int s = 0; s < 4; s++) begin
            set_in(s >> 1, s & 1, ReLU, Sigmoid);
            step();
            if (s == 3) begin
                check_cond("and_11", bus.prediction[0] > HALF, bus.prediction[0], "> HALF");
            end else begin
                check_cond($sformatf("and_%0d", s), bus.prediction[0] <= HALF,
                           bus.prediction[0], "<= HALF");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
